// File: rtl/tx_fifo_wr_ingress.sv
// -----------------------------------------------------------------------------
// tx_fifo_wr_ingress
//
// Write-side ingress stage for the TX async FIFO (write clock domain).
// It accepts a valid/ready packet stream, holds it in a 2-entry skid buffer,
// and drives the FIFO controller's push request and the dual-port RAM write
// port. Whether a packet is admitted is decided only at the packet start,
// based on the controller's almost-full flag. The block also keeps saturating
// packet and drop statistics.
//
// Optional feature (compile-time macro):
//   TX_INGRESS_DROP_ON_AFULL_EN
//     Defined   - a packet that starts while almost-full is asserted is
//                 discarded at 1 word/cycle and counted in o_drop_cnt.
//     Undefined - such a packet waits until almost-full clears.
//                 o_drop_cnt is tied to 0.
//
// Ports:
//   i_wclk, i_wrst_n     write clock; asynchronous active-low reset
//   i_s_valid/o_s_ready  upstream handshake (o_s_ready is registered)
//   i_s_data, i_s_last   upstream word and end-of-packet marker
//   o_push               push request to the FIFO controller
//   i_wren, i_wptr       controller push-accept and write address
//   i_afull              controller almost-full flag
//   o_ram_we/waddr/wdata RAM write port; wdata = {last, data}
//   o_pkt_cnt            packets fully written (saturating)
//   o_drop_cnt           packets discarded (saturating, feature only)
// -----------------------------------------------------------------------------
module tx_fifo_wr_ingress #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PTR_WIDTH  = 10,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  i_wclk,
  input  logic                  i_wrst_n,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  input  logic [DATA_WIDTH-1:0] i_s_data,
  input  logic                  i_s_last,
  output logic                  o_push,
  input  logic                  i_wren,
  input  logic [PTR_WIDTH-1:0]  i_wptr,
  input  logic                  i_afull,
  output logic                  o_ram_we,
  output logic [PTR_WIDTH-1:0]  o_ram_waddr,
  output logic [DATA_WIDTH:0]   o_ram_wdata,
  output logic [CNT_WIDTH-1:0]  o_pkt_cnt,
  output logic [CNT_WIDTH-1:0]  o_drop_cnt
);

  localparam int unsigned WORD_W = DATA_WIDTH + 1;

`ifdef TX_INGRESS_DROP_ON_AFULL_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_PASS = 2'd2,
    ST_DROP = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_PASS = 2'd2
  } state_t;
`endif

  // Skid buffer: head_q is the output stage; tail_q is used only when both
  // entries are occupied.
  logic [WORD_W-1:0]    head_q, tail_q, head_nxt, tail_nxt;
  logic [1:0]           occ_q, occ_nxt;
  logic                 ready_q, ready_nxt;
  logic                 push_q, push_nxt;
  state_t               state_q, state_nxt;
  logic [CNT_WIDTH-1:0] pkt_cnt_q;

  logic                 accept;
  logic                 head_last;
  logic                 pop_wr;
  logic                 pop_drop;
  logic                 pop;
  logic                 boundary;
  logic [WORD_W-1:0]    in_word;

  always_comb begin
    in_word   = {i_s_last, i_s_data};
    accept    = i_s_valid & ready_q;
    head_last = head_q[DATA_WIDTH];
    // push_q already implies PASS with a valid head, so i_wren pops exactly
    // the word that the RAM is writing.
    pop_wr    = push_q & i_wren;
`ifdef TX_INGRESS_DROP_ON_AFULL_EN
    pop_drop  = (state_q == ST_DROP) & (occ_q != 2'd0);
`else
    pop_drop  = 1'b0;
`endif
    pop       = pop_wr | pop_drop;

    head_nxt = head_q;
    tail_nxt = tail_q;
    occ_nxt  = occ_q;
    case ({accept, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_nxt = in_word;
        else               tail_nxt = in_word;
        occ_nxt = occ_q + 2'd1;
      end
      2'b01: begin
        head_nxt = tail_q;
        occ_nxt  = occ_q - 2'd1;
      end
      2'b11: begin
        // Accept and pop together: occupancy is unchanged, the queue shifts.
        if (occ_q == 2'd1) begin
          head_nxt = in_word;
        end else begin
          head_nxt = tail_q;
          tail_nxt = in_word;
        end
      end
      default: ;
    endcase

    ready_nxt = (occ_nxt != 2'd2);

    // The admission decision looks at the head that will be present after
    // this edge. That lets a word arriving in IDLE, or a word that follows a
    // popped last word, start pushing on the very next cycle.
    boundary  = (state_q == ST_IDLE) | (state_q == ST_WAIT) | (pop & head_last);
    state_nxt = state_q;
    if (boundary) begin
      if (occ_nxt == 2'd0) begin
        state_nxt = ST_IDLE;
      end else if (!i_afull) begin
        state_nxt = ST_PASS;
      end else begin
`ifdef TX_INGRESS_DROP_ON_AFULL_EN
        state_nxt = ST_DROP;
`else
        state_nxt = ST_WAIT;
`endif
      end
    end
    push_nxt = (state_nxt == ST_PASS) & (occ_nxt != 2'd0);
  end

  // Control FSM with registered push and ready outputs.
  always_ff @(posedge i_wclk or negedge i_wrst_n) begin
    if (!i_wrst_n) begin
      state_q <= ST_IDLE;
      push_q  <= 1'b0;
      ready_q <= 1'b0;
      occ_q   <= 2'd0;
    end else begin
      state_q <= state_nxt;
      push_q  <= push_nxt;
      ready_q <= ready_nxt;
      occ_q   <= occ_nxt;
    end
  end

  always_ff @(posedge i_wclk or negedge i_wrst_n) begin
    if (!i_wrst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_nxt;
      tail_q <= tail_nxt;
    end
  end

  always_ff @(posedge i_wclk or negedge i_wrst_n) begin
    if (!i_wrst_n) begin
      pkt_cnt_q <= '0;
    end else if (pop_wr && head_last && (pkt_cnt_q != '1)) begin
      pkt_cnt_q <= pkt_cnt_q + CNT_WIDTH'(1);
    end
  end

`ifdef TX_INGRESS_DROP_ON_AFULL_EN
  logic [CNT_WIDTH-1:0] drop_cnt_q;

  always_ff @(posedge i_wclk or negedge i_wrst_n) begin
    if (!i_wrst_n) begin
      drop_cnt_q <= '0;
    end else if (pop_drop && head_last && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign o_drop_cnt = drop_cnt_q;
`else
  assign o_drop_cnt = '0;
`endif

  assign o_s_ready   = ready_q;
  assign o_push      = push_q;
  assign o_ram_we    = i_wren;
  assign o_ram_waddr = i_wptr;
  assign o_ram_wdata = head_q;
  assign o_pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_tx_fifo_wr_ingress.sv
// -----------------------------------------------------------------------------
// tb_tx_fifo_wr_ingress
//
// Directed testbench for tx_fifo_wr_ingress. A minimal controller model grants
// every push (unless stalled) and advances a write pointer. Every RAM write is
// recorded and compared against hand-computed expected words and addresses.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tx_fifo_wr_ingress;

  logic       i_wclk;
  logic       i_wrst_n;
  logic       i_s_valid;
  logic       o_s_ready;
  logic [7:0] i_s_data;
  logic       i_s_last;
  logic       o_push;
  logic       i_wren;
  logic [9:0] i_wptr;
  logic       i_afull;
  logic       o_ram_we;
  logic [9:0] o_ram_waddr;
  logic [8:0] o_ram_wdata;
  logic [15:0] o_pkt_cnt;
  logic [15:0] o_drop_cnt;

  tx_fifo_wr_ingress #(
    .DATA_WIDTH (8),
    .PTR_WIDTH  (10),
    .CNT_WIDTH  (16)
  ) dut (
    .i_wclk      (i_wclk),
    .i_wrst_n    (i_wrst_n),
    .i_s_valid   (i_s_valid),
    .o_s_ready   (o_s_ready),
    .i_s_data    (i_s_data),
    .i_s_last    (i_s_last),
    .o_push      (o_push),
    .i_wren      (i_wren),
    .i_wptr      (i_wptr),
    .i_afull     (i_afull),
    .o_ram_we    (o_ram_we),
    .o_ram_waddr (o_ram_waddr),
    .o_ram_wdata (o_ram_wdata),
    .o_pkt_cnt   (o_pkt_cnt),
    .o_drop_cnt  (o_drop_cnt)
  );

  initial i_wclk = 1'b0;
  always #5 i_wclk = ~i_wclk;

  // Controller model: grants every push unless wren_en stalls it.
  logic wren_en;
  always_comb i_wren = o_push & wren_en;

  always_ff @(posedge i_wclk or negedge i_wrst_n) begin
    if (!i_wrst_n) i_wptr <= '0;
    else if (i_wren) i_wptr <= i_wptr + 10'd1;
  end

  int cyc = 0;
  always @(posedge i_wclk) cyc <= cyc + 1;

  typedef struct {
    logic [9:0] addr;
    logic [8:0] data;
    int         cyc;
  } wr_t;

  wr_t wr_q[$];
  always @(negedge i_wclk) begin
    if (o_ram_we) wr_q.push_back('{o_ram_waddr, o_ram_wdata, cyc});
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [8:0] src_q[$];
  int         acc_q[$];
  logic       rdy_drop;
  int         exp_idx;
  int         exp_addr;

  task automatic drive_src();
    if (src_q.size() != 0) begin
      i_s_valid = 1'b1;
      {i_s_last, i_s_data} = src_q[0];
    end else begin
      i_s_valid = 1'b0;
      i_s_last  = 1'b0;
      i_s_data  = '0;
    end
  endtask

  // One clock: sample handshake at the falling edge, update the source after
  // the rising edge.
  task automatic cycle();
    logic fire;
    @(negedge i_wclk);
    fire = i_s_valid & o_s_ready;
    if (fire) acc_q.push_back(cyc);
    if (!o_s_ready && i_wrst_n) rdy_drop = 1'b1;
    @(posedge i_wclk);
    #1;
    if (fire) void'(src_q.pop_front());
    drive_src();
  endtask

  task automatic send_pkt(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) src_q.push_back({(i == n - 1), base + 8'(i)});
    drive_src();
  endtask

  task automatic run_until_pkt(input string tag, input logic [15:0] target, input int budget);
    int n;
    n = 0;
    while (o_pkt_cnt !== target && n < budget) begin
      cycle();
      n++;
    end
    check(tag, 32'(o_pkt_cnt), 32'(target));
  endtask

  task automatic run_until_writes(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (wr_q.size() < target && n < budget) begin
      cycle();
      n++;
    end
    check(tag, wr_q.size(), target);
  endtask

  task automatic expect_wr(input string tag, input logic last, input logic [7:0] data);
    if (exp_idx < wr_q.size()) begin
      check({tag, "_addr"}, 32'(wr_q[exp_idx].addr), exp_addr);
      check({tag, "_data"}, 32'(wr_q[exp_idx].data), 32'({last, data}));
    end else begin
      check({tag, "_missing"}, wr_q.size(), exp_idx + 1);
    end
    exp_idx++;
    exp_addr++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base;

  initial begin
    i_wrst_n  = 1'b0;
    i_s_valid = 1'b0;
    i_s_data  = '0;
    i_s_last  = 1'b0;
    i_afull   = 1'b0;
    wren_en   = 1'b1;
    rdy_drop  = 1'b0;
    exp_idx   = 0;
    exp_addr  = 0;

    // Reset values
    repeat (3) @(posedge i_wclk);
    #1;
    check("rst_ready",    32'(o_s_ready),  0);
    check("rst_push",     32'(o_push),     0);
    check("rst_ram_we",   32'(o_ram_we),   0);
    check("rst_pkt_cnt",  32'(o_pkt_cnt),  0);
    check("rst_drop_cnt", 32'(o_drop_cnt), 0);
    i_wrst_n = 1'b1;
    cycle();
    check("rst_ready_after", 32'(o_s_ready), 1);

    // 4-word packet at full rate
    rdy_drop = 1'b0;
    acc_q.delete();
    send_pkt(8'h11, 4);
    run_until_pkt("t1_pkt_cnt", 16'd1, 20);
    for (int i = 0; i < 4; i++) expect_wr("t1_w", (i == 3), 8'h11 + 8'(i));
    check("t1_wr_count", wr_q.size(), exp_idx);
    if (wr_q.size() >= 4 && acc_q.size() >= 1) begin
      check("t1_latency", wr_q[0].cyc, acc_q[0] + 1);
      check("t1_consec",  wr_q[3].cyc, wr_q[0].cyc + 3);
    end else begin
      check("t1_timing_data", wr_q.size(), 4);
    end
    check("t1_ready_held", 32'(rdy_drop), 0);

    // Controller stall mid-packet
    send_pkt(8'h21, 6);
    run_until_writes("t2_pre_stall", exp_idx + 2, 20);
    wren_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t2_head_hold", 32'(o_ram_wdata), 32'h023);
      check("t2_no_we",     32'(o_ram_we),    0);
      cycle();
    end
    check("t2_ready_low", 32'(o_s_ready), 0);
    wren_en = 1'b1;
    run_until_pkt("t2_pkt_cnt", 16'd2, 20);
    for (int i = 0; i < 6; i++) expect_wr("t2_w", (i == 5), 8'h21 + 8'(i));
    check("t2_wr_count", wr_q.size(), exp_idx);

`ifdef TX_INGRESS_DROP_ON_AFULL_EN
    // Almost-full at packet start discards the whole packet
    i_afull  = 1'b1;
    rdy_drop = 1'b0;
    send_pkt(8'h41, 5);
    repeat (8) cycle();
    check("t3d_no_write",   wr_q.size(), exp_idx);
    check("t3d_ready_held", 32'(rdy_drop), 0);
    check("t3d_drop_cnt",   32'(o_drop_cnt), 1);
    check("t3d_src_empty",  src_q.size(), 0);
    i_afull = 1'b0;
    send_pkt(8'h51, 2);
    run_until_pkt("t3d_pkt_cnt", 16'd3, 20);
    expect_wr("t3d_w", 1'b0, 8'h51);
    expect_wr("t3d_w", 1'b1, 8'h52);
    check("t3d_wr_count", wr_q.size(), exp_idx);
`else
    // Almost-full at packet start waits; almost-full mid-packet is ignored
    i_afull = 1'b1;
    send_pkt(8'h31, 3);
    repeat (4) cycle();
    check("t3_wait_no_push",  32'(o_push), 0);
    check("t3_wait_no_write", wr_q.size(), exp_idx);
    check("t3_wait_bp",       32'(o_s_ready), 0);
    i_afull = 1'b0;
    cycle();
    check("t3_push_after_afull", 32'(o_push), 1);
    i_afull = 1'b1;
    run_until_pkt("t3_pkt_cnt", 16'd3, 20);
    expect_wr("t3_w", 1'b0, 8'h31);
    expect_wr("t3_w", 1'b0, 8'h32);
    expect_wr("t3_w", 1'b1, 8'h33);
    check("t3_wr_count", wr_q.size(), exp_idx);
    i_afull = 1'b0;
    check("t3_drop_cnt_zero", 32'(o_drop_cnt), 0);
`endif

    // Back-to-back single-word packets
    base = exp_idx;
    for (int i = 0; i < 6; i++) src_q.push_back({1'b1, 8'h61 + 8'(i)});
    drive_src();
    run_until_pkt("t4_pkt_cnt", 16'd9, 20);
    for (int i = 0; i < 6; i++) expect_wr("t4_w", 1'b1, 8'h61 + 8'(i));
    check("t4_wr_count", wr_q.size(), exp_idx);
    if (wr_q.size() >= base + 6) check("t4_full_rate", wr_q[base + 5].cyc, wr_q[base].cyc + 5);

    // Packet counter saturation
    force dut.pkt_cnt_q = 16'hFFFE;
    #1;
    release dut.pkt_cnt_q;
    for (int i = 0; i < 3; i++) src_q.push_back({1'b1, 8'h71 + 8'(i)});
    drive_src();
    run_until_pkt("t5_sat_reach", 16'hFFFF, 20);
    repeat (4) cycle();
    check("t5_sat_hold", 32'(o_pkt_cnt), 32'h0000FFFF);
    for (int i = 0; i < 3; i++) expect_wr("t5_w", 1'b1, 8'h71 + 8'(i));
    check("t5_wr_count", wr_q.size(), exp_idx);

    // Reset mid-packet
    send_pkt(8'h81, 6);
    run_until_writes("t6_pre_rst", exp_idx + 2, 20);
    expect_wr("t6_w", 1'b0, 8'h81);
    expect_wr("t6_w", 1'b0, 8'h82);
    i_wrst_n = 1'b0;
    src_q.delete();
    drive_src();
    #1;
    check("t6_rst_ready",    32'(o_s_ready),   0);
    check("t6_rst_push",     32'(o_push),      0);
    check("t6_rst_ram_we",   32'(o_ram_we),    0);
    check("t6_rst_pkt_cnt",  32'(o_pkt_cnt),   0);
    check("t6_rst_drop_cnt", 32'(o_drop_cnt),  0);
    check("t6_rst_waddr",    32'(o_ram_waddr), 0);
    repeat (2) cycle();
    i_wrst_n = 1'b1;
    exp_addr = 0;
    cycle();
    send_pkt(8'h91, 2);
    run_until_pkt("t6_pkt_cnt", 16'd1, 20);
    expect_wr("t6_post", 1'b0, 8'h91);
    expect_wr("t6_post", 1'b1, 8'h92);
    check("t6_wr_count", wr_q.size(), exp_idx);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
